// File: rtl/imm_encoder_if.sv
// ============================================================================
// Module     : imm_encoder_if
// Description: Request/result bundle for the ARM immediate encoder. The
//              requester drives start/value/allow_inv; the encoder returns
//              busy/done and the held encoding result.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imm_encoder_if;
  logic        start;
  logic [31:0] value;
  logic        allow_inv;
  logic        busy;
  logic        done;
  logic        valid;
  logic        inv;
  logic [11:0] shiftOprand;

  // Requester side
  modport master (
    output start,
    output value,
    output allow_inv,
    input  busy,
    input  done,
    input  valid,
    input  inv,
    input  shiftOprand
  );

  // Encoder side
  modport slave (
    input  start,
    input  value,
    input  allow_inv,
    output busy,
    output done,
    output valid,
    output inv,
    output shiftOprand
  );
endinterface

`default_nettype wire

// File: rtl/imm_encoder.sv
// ============================================================================
// Module     : imm_encoder
// Description: Sequential search for an ARM data-processing immediate
//              (8-bit constant rotated right by an even amount). One rotation
//              is tried per cycle, smallest first; optionally the bitwise
//              inverse is searched afterwards for an MVN-style encoding.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_encoder (
  input  wire logic    clk,
  input  wire logic    rst,   // asynchronous, active-low
  imm_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEARCH     = 2'd1,
    SEARCH_INV = 2'd2
  } state_t;

  localparam logic [3:0] C_ROT_LAST = 4'd15;

  state_t      state_q, state_d;
  logic [3:0]  rot_q, rot_d;
  logic [31:0] value_q, value_d;
  logic        allow_inv_q, allow_inv_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;
  logic        inv_q, inv_d;
  logic [11:0] shop_q, shop_d;

  logic [31:0] w_word;
  logic [63:0] w_dbl;
  logic [5:0]  w_lo_idx;
  logic [31:0] w_cand;
  logic        w_hit;

  // Candidate for the current rotation: ROL(word, 2*r) taken as a 32-bit
  // window out of the doubled word, so the rotation wraps naturally.
  always_comb begin
    w_word   = (state_q == SEARCH_INV) ? ~value_q : value_q;
    w_dbl    = {w_word, w_word};
    w_lo_idx = 6'd32 - {1'b0, rot_q, 1'b0};
    w_cand   = w_dbl[w_lo_idx +: 32];
    w_hit    = (w_cand[31:8] == 24'd0);
  end

  // Next-state and result logic; done is a single-cycle pulse by default.
  always_comb begin
    state_d     = state_q;
    rot_d       = rot_q;
    value_d     = value_q;
    allow_inv_d = allow_inv_q;
    done_d      = 1'b0;
    valid_d     = valid_q;
    inv_d       = inv_q;
    shop_d      = shop_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          value_d     = bus.value;
          allow_inv_d = bus.allow_inv;
          rot_d       = 4'd0;
          state_d     = SEARCH;
        end
      end

      SEARCH, SEARCH_INV: begin
        if (w_hit) begin
          shop_d  = {rot_q, w_cand[7:0]};
          valid_d = 1'b1;
          inv_d   = (state_q == SEARCH_INV);
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (rot_q == C_ROT_LAST) begin
          if ((state_q == SEARCH) && allow_inv_q) begin
            // Plain form exhausted; retry on the inverted constant.
            rot_d   = 4'd0;
            state_d = SEARCH_INV;
          end else begin
            valid_d = 1'b0;
            inv_d   = 1'b0;
            shop_d  = 12'h000;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          rot_d = rot_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rot_q       <= 4'd0;
      value_q     <= 32'd0;
      allow_inv_q <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      inv_q       <= 1'b0;
      shop_q      <= 12'h000;
    end else begin
      state_q     <= state_d;
      rot_q       <= rot_d;
      value_q     <= value_d;
      allow_inv_q <= allow_inv_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      inv_q       <= inv_d;
      shop_q      <= shop_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.valid       = valid_q;
  assign bus.inv         = inv_q;
  assign bus.shiftOprand = shop_q;

endmodule

`default_nettype wire

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset (0 = reset).
REQ-004 start  input  1  request pulse; sampled only when busy=0.
REQ-005 value  input  32  constant to encode; captured on the accepted start edge.
REQ-006 allow_inv  input  1  permit MVN-style encoding of ~value; captured with value.
REQ-007 busy  output  1  high whenever state != IDLE.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 valid  output  1  result is encodable; meaningful while done=1 and held until the next accepted start.
REQ-010 inv  output  1  encoding is of ~value (MVN form); held like valid.
REQ-011 shiftOprand  output  12  {rotate_imm[3:0], immed_8[7:0]} such that ROR(zero-extended immed_8, 2*rotate_imm) equals the encoded word; held like valid.

Function
REQ-012 States SHALL be IDLE, SEARCH, SEARCH_INV.
REQ-013 A 4-bit rotation counter r SHALL select the candidate: cand = ROL(word, 2*r), where word = captured value in SEARCH and ~captured value in SEARCH_INV.
REQ-014 Hit condition SHALL be cand[31:8]==0. On a hit: immed_8=cand[7:0], rotate_imm=r.
REQ-015 IDLE: on a clock edge with start=1, capture value and allow_inv, clear r, go to SEARCH. Otherwise stay in IDLE.
REQ-016 SEARCH/SEARCH_INV: exactly one r SHALL be tested per cycle, in ascending order 0..15. The first (smallest) hitting r wins.
REQ-017 On a hit edge: register shiftOprand, valid=1, inv=(state==SEARCH_INV); set done=1 for the next cycle only; go to IDLE.
REQ-018 Miss at r=15 in SEARCH with allow_inv=1: clear r, go to SEARCH_INV, no done.
REQ-019 Miss at r=15 in SEARCH with allow_inv=0, or in SEARCH_INV: valid=0, inv=0, shiftOprand=0, done=1 for one cycle, go to IDLE.
REQ-020 Latency, counted from the start-sampling edge E0: hit at r=k in SEARCH gives done high after edge E(k+1). Hit in SEARCH_INV gives done after E(17+k). Full miss gives done after E16 (no inversion) or E32 (with inversion).
REQ-021 start while busy=1 SHALL be ignored, with no effect on captured operands or the search.
REQ-022 start during the done cycle SHALL be accepted, since state is IDLE; the new search starts immediately.
REQ-023 Input value changes after capture SHALL NOT affect the result.
REQ-024 Rotations SHALL wrap modulo 32. r SHALL wrap 15->0 only at a SEARCH->SEARCH_INV transition.

Reset
REQ-025 rst=0 SHALL immediately, without waiting for clk, force state=IDLE, r=0, busy=0, done=0, valid=0, inv=0, shiftOprand=12'h000.
REQ-026 Reset asserted mid-search SHALL abort with no done pulse. After release the block SHALL accept a new start.

Verification
REQ-027 value=32'h000000FF, allow_inv=0 -> done after E1, valid=1, inv=0, shiftOprand=12'h0FF.
REQ-028 value=32'hFF000000 -> done after E5, shiftOprand=12'h4FF. Separately, value=32'h000003FC -> done after E16, shiftOprand=12'hFFF.
REQ-029 value=32'hFFFFFFFF, allow_inv=1 -> done after E17, valid=1, inv=1, shiftOprand=12'h000. Same value with allow_inv=0 -> done after E16, valid=0.
REQ-030 value=32'h00000101, allow_inv=1 -> busy for 32 cycles, done after E32, valid=0, shiftOprand=12'h000. Also check that a start pulse issued mid-search is ignored.
REQ-031 Reset asserted at cycle 5 of the 32'h00000101 search -> outputs cleared asynchronously and no done pulse. After release, start with value=32'h00000000 -> done after E1, valid=1, shiftOprand=12'h000.
REQ-032 Back-to-back operation: start asserted during the done cycle of the 32'h000000FF case with value=32'hFF000000 -> second done exactly 5 edges after that start edge.
